// File: rtl/vwi_pkg.sv
// Shared types and defaults for the virtual-wire transmit packer.
// Build option VWI_IN_SYNC_EN (see vwi_tx_packer) adds an input synchroniser.
package vwi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } vwi_state_e;

    localparam int VWI_NUM_WIRES_DEF = 64;
    localparam int VWI_CHUNK_W_DEF   = 16;

    // Chunk index width, never narrower than one bit.
    function automatic int vwi_idx_w(input int num_chunks);
        return (num_chunks <= 2) ? 1 : $clog2(num_chunks);
    endfunction

endpackage

// File: rtl/vwi_sync.sv
// Parametrised-width two-flop synchroniser; both stages reset to a per-bit value.
module vwi_sync #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_rst_val,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= i_rst_val;
            r_sync <= i_rst_val;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/vwi_tx_packer.sv
// Packs virtual wires into CHUNK_W-wide sideband messages, resending only changed chunks.
// Define VWI_IN_SYNC_EN to pass async_virt_in through a 2-flop synchroniser before sampling.
//
// state | meaning
// IDLE  | link not ready; shadow follows the strap defaults; nothing sent
// INIT  | sending every chunk once, index 0 upward
// RUN   | sending only chunks that differ from the last values sent
// DRAIN | link dropped with a message outstanding; hold it until accepted
module vwi_tx_packer
    import vwi_pkg::*;
#(
    parameter  int NUM_WIRES  = VWI_NUM_WIRES_DEF,
    parameter  int CHUNK_W    = VWI_CHUNK_W_DEF,
    localparam int NUM_CHUNKS = NUM_WIRES / CHUNK_W,
    localparam int IDX_W      = vwi_idx_w(NUM_CHUNKS)
) (
    input  logic                 d2d_sb_clk,
    input  logic                 d2d_sb_rst,
    input  logic [NUM_WIRES-1:0] async_virt_in,
    input  logic [NUM_WIRES-1:0] strap_default_wires_in,
    input  logic                 ip_ready,
    output logic                 msg_valid,
    input  logic                 msg_ready,
    output logic [IDX_W-1:0]     msg_idx,
    output logic [CHUNK_W-1:0]   msg_data,
    output logic                 vw_pending
);

    typedef logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] chunks_t;

    chunks_t w_strap;
    chunks_t w_in;
    chunks_t r_samp;
    chunks_t r_shadow;

    assign w_strap = strap_default_wires_in;

`ifdef VWI_IN_SYNC_EN
    logic [NUM_WIRES-1:0] w_sync_q;

    vwi_sync #(.WIDTH(NUM_WIRES)) u_sync (
        .i_clk     (d2d_sb_clk),
        .i_rst     (d2d_sb_rst),
        .i_rst_val (strap_default_wires_in),
        .i_d       (async_virt_in),
        .o_q       (w_sync_q)
    );

    assign w_in = w_sync_q;
`else
    assign w_in = async_virt_in;
`endif

    vwi_state_e         r_state;
    vwi_state_e         w_state_nxt;
    logic               r_msg_valid;
    logic [IDX_W-1:0]   r_msg_idx;
    logic [CHUNK_W-1:0] r_msg_data;
    logic               r_vw_pending;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W:0]     r_init_ptr;

    logic                  w_hs;
    logic                  w_slot_free;
    logic                  w_init_more;
    logic                  w_init_last;
    logic [IDX_W-1:0]      w_idx_inc;
    logic [IDX_W-1:0]      w_arb_base;
    logic [NUM_CHUNKS-1:0] w_dirty;
    logic [NUM_CHUNKS-1:0] w_dirty_eff;
    logic                  w_arb_found;
    logic [IDX_W-1:0]      w_arb_idx;
    logic                  w_cap;
    logic                  w_cap_init;
    logic [IDX_W-1:0]      w_cap_idx;

    assign w_hs        = r_msg_valid && msg_ready;
    assign w_slot_free = !r_msg_valid || w_hs;
    assign w_init_more = (r_init_ptr != (IDX_W+1)'(NUM_CHUNKS));
    assign w_init_last = (r_state == INIT) && w_hs && (r_msg_idx == IDX_W'(NUM_CHUNKS - 1));
    assign w_idx_inc   = (r_msg_idx == IDX_W'(NUM_CHUNKS - 1)) ? '0 : r_msg_idx + 1'b1;
    assign w_arb_base  = ((r_state == RUN) && w_hs) ? w_idx_inc : r_rr_ptr;

    // The chunk being accepted this cycle is judged against the data it carries,
    // so back-to-back arbitration sees the shadow as it will be after the update.
    always_comb begin
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            w_dirty[i] = (r_samp[i] != r_shadow[i]);
        end
        w_dirty_eff = w_dirty;
        if (w_hs) begin
            w_dirty_eff[r_msg_idx] = (r_samp[r_msg_idx] != r_msg_data);
        end
    end

    always_comb begin
        int j;
        j           = 0;
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            j = int'(w_arb_base) + k;
            if (j >= NUM_CHUNKS) begin
                j = j - NUM_CHUNKS;
            end
            if (!w_arb_found && w_dirty_eff[j]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = j[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_cap      = 1'b0;
        w_cap_init = 1'b0;
        w_cap_idx  = '0;
        if (ip_ready && w_slot_free) begin
            if ((r_state == INIT) && w_init_more) begin
                w_cap      = 1'b1;
                w_cap_init = 1'b1;
                w_cap_idx  = r_init_ptr[IDX_W-1:0];
            end else if (((r_state == RUN) || w_init_last) && w_arb_found) begin
                w_cap     = 1'b1;
                w_cap_idx = w_arb_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (ip_ready) w_state_nxt = INIT;
            end
            INIT, RUN: begin
                if (!ip_ready)        w_state_nxt = (r_msg_valid && !w_hs) ? DRAIN : IDLE;
                else if (w_init_last) w_state_nxt = RUN;
            end
            DRAIN: begin
                if (w_hs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge d2d_sb_clk or posedge d2d_sb_rst) begin
        if (d2d_sb_rst) begin
            r_state      <= IDLE;
            r_msg_valid  <= 1'b0;
            r_msg_idx    <= '0;
            r_msg_data   <= '0;
            r_vw_pending <= 1'b0;
            r_rr_ptr     <= '0;
            r_init_ptr   <= '0;
            r_samp       <= w_strap;
            r_shadow     <= w_strap;
        end else begin
            r_state <= w_state_nxt;
            r_samp  <= w_in;

            if (w_cap) begin
                r_msg_valid <= 1'b1;
                r_msg_idx   <= w_cap_idx;
                r_msg_data  <= r_samp[w_cap_idx];
            end else if (w_hs) begin
                r_msg_valid <= 1'b0;
            end

            if (r_state == IDLE) begin
                r_init_ptr <= '0;
            end else if (w_cap_init) begin
                r_init_ptr <= r_init_ptr + 1'b1;
            end

            if ((r_state == RUN) && w_hs) begin
                r_rr_ptr <= w_idx_inc;
            end

            // Returning to IDLE discards whatever was sent; the strap is the reference again.
            if ((r_state == IDLE) || (w_state_nxt == IDLE)) begin
                r_shadow <= w_strap;
            end else if (w_hs) begin
                r_shadow[r_msg_idx] <= r_msg_data;
            end

            r_vw_pending <= (w_state_nxt == IDLE) ? 1'b0 : |w_dirty;
        end
    end

    assign msg_valid  = r_msg_valid;
    assign msg_idx    = r_msg_idx;
    assign msg_data   = r_msg_data;
    assign vw_pending = r_vw_pending;

endmodule

// File: tb/tb_vwi_tx_packer.sv
// Scoreboard bench for vwi_tx_packer: directed scenarios plus randomized wire changes.
module tb_vwi_tx_packer;

    localparam int NW = 64;
    localparam int CW = 16;
    localparam int NC = NW / CW;

    typedef struct {
        int            idx;
        logic [CW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NW-1:0] vin;
    logic [NW-1:0] strap;
    logic          ip_ready;
    logic          msg_ready;
    logic          msg_valid;
    logic [1:0]    msg_idx;
    logic [CW-1:0] msg_data;
    logic          vw_pending;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t exp_q[$];
    int   hs_cyc_q[$];

    logic [NW-1:0] m_shadow;
    logic [NW-1:0] m_in;
    int            m_rr;
    bit            rand_ready = 1'b0;

    always #5 clk = ~clk;

    vwi_tx_packer #(.NUM_WIRES(NW), .CHUNK_W(CW)) dut (
        .d2d_sb_clk             (clk),
        .d2d_sb_rst             (rst),
        .async_virt_in          (vin),
        .strap_default_wires_in (strap),
        .ip_ready               (ip_ready),
        .msg_valid              (msg_valid),
        .msg_ready              (msg_ready),
        .msg_idx                (msg_idx),
        .msg_data               (msg_data),
        .vw_pending             (vw_pending)
    );

    function automatic logic [CW-1:0] chunk_of(input logic [NW-1:0] v, input int i);
        return v[i*CW +: CW];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: all chunks that differ from what was last sent go out in
    // ascending rotation starting at the round-robin pointer.
    task automatic run_change(input logic [NW-1:0] nv);
        int last;
        last = -1;
        for (int k = 0; k < NC; k++) begin
            int j;
            j = (m_rr + k) % NC;
            if (chunk_of(nv, j) != chunk_of(m_shadow, j)) begin
                exp_q.push_back(exp_t'{j, chunk_of(nv, j)});
                last = j;
            end
        end
        if (last >= 0) m_rr = (last + 1) % NC;
        m_shadow = nv;
        m_in     = nv;
        vin      = nv;
    endtask

    task automatic push_init();
        for (int i = 0; i < NC; i++) exp_q.push_back(exp_t'{i, chunk_of(m_in, i)});
        m_shadow = m_in;
    endtask

    task automatic wait_quiet(input string name);
        int quiet;
        int budget;
        quiet  = 0;
        budget = 400;
        while (quiet < 4 && budget > 0) begin
            if (rand_ready) msg_ready = 1'($urandom_range(0, 1));
            tick(1);
            budget--;
            if (exp_q.size() == 0 && !msg_valid) quiet++;
            else quiet = 0;
        end
        msg_ready = 1'b1;
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL %s: timeout, got %0d messages outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic wait_valid(input string name);
        int budget;
        budget = 20;
        while (!msg_valid && budget > 0) begin
            tick(1);
            budget--;
        end
        checks++;
        if (!msg_valid) begin
            errors++;
            $display("FAIL %s: msg_valid got 0 expected 1 within 20 cycles", name);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stalled messages stay put.
    initial begin
        bit            held;
        logic [1:0]    h_idx;
        logic [CW-1:0] h_data;
        exp_t          e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                checks++;
                if (!msg_valid || msg_idx != h_idx || msg_data != h_data) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%0b idx=%0d data=0x%0h expected v=1 idx=%0d data=0x%0h",
                             msg_valid, msg_idx, msg_data, h_idx, h_data);
                end
            end
            if (msg_valid && msg_ready) begin
                hs_cyc_q.push_back(cyc);
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_msg: got idx=%0d data=0x%0h expected no message", msg_idx, msg_data);
                end else begin
                    e = exp_q.pop_front();
                    check("msg_idx", 64'(msg_idx), 64'(e.idx));
                    check("msg_data", 64'(msg_data), 64'(e.data));
                end
            end else if (msg_valid) begin
                held   = 1'b1;
                h_idx  = msg_idx;
                h_data = msg_data;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NW-1:0] nv;
        int            n0;
        int            held1;

        strap     = 64'hFFFF_0000_0000_1234;
        vin       = strap;
        m_in      = strap;
        m_shadow  = strap;
        m_rr      = 0;
        ip_ready  = 1'b0;
        msg_ready = 1'b0;
        rst       = 1'b1;
        tick(2);
        check("rst_valid", 64'(msg_valid), 0);
        check("rst_idx", 64'(msg_idx), 0);
        check("rst_data", 64'(msg_data), 0);
        check("rst_pending", 64'(vw_pending), 0);

        rst = 1'b0;
        tick(3);
        check("idle_valid", 64'(msg_valid), 0);
        check("idle_pending", 64'(vw_pending), 0);

        // Scenario 1: INIT sends all four chunks back-to-back.
        push_init();
        n0        = hs_cyc_q.size();
        msg_ready = 1'b1;
        ip_ready  = 1'b1;
        wait_quiet("s1");
        check("s1_count", 64'(hs_cyc_q.size() - n0), 4);
        if (hs_cyc_q.size() >= n0 + 4) check("s1_b2b_span", 64'(hs_cyc_q[n0+3] - hs_cyc_q[n0]), 3);
        tick(2);
        check("s1_pending", 64'(vw_pending), 0);

        // Scenario 3: chunks 1 and 3 dirty, sink stalled.
        msg_ready = 1'b0;
        nv = m_in;
        nv[31:16] = nv[31:16] ^ 16'h00A5;
        nv[63:48] = nv[63:48] ^ 16'h0F00;
        run_change(nv);
        held1 = 0;
        repeat (12) begin
            tick(1);
            if (msg_valid && msg_idx == 2'd1) held1++;
        end
        check("s3_held_cycles", 64'(held1), 11);
        check("s3_pending", 64'(vw_pending), 1);
        n0        = hs_cyc_q.size();
        msg_ready = 1'b1;
        wait_quiet("s3");
        check("s3_count", 64'(hs_cyc_q.size() - n0), 2);
        if (hs_cyc_q.size() >= n0 + 2) check("s3_b2b", 64'(hs_cyc_q[n0+1] - hs_cyc_q[n0]), 1);

        // Scenario 2: bit 40 rises; one message, two cycles of latency.
        n0 = hs_cyc_q.size();
        nv = m_in;
        nv[40] = 1'b1;
        run_change(nv);
        @(negedge clk);
        @(negedge clk);
        check("s2_lat_early", 64'(msg_valid), 0);
        @(negedge clk);
        check("s2_lat_valid", 64'(msg_valid), 1);
        check("s2_idx", 64'(msg_idx), 2);
        check("s2_data", 64'(msg_data), 64'h0100);
        wait_quiet("s2");
        check("s2_count", 64'(hs_cyc_q.size() - n0), 1);

        // Scenario 4: chunk 0 changes again while its message is stalled.
        msg_ready = 1'b0;
        nv = m_in;
        nv[15:0] = nv[15:0] ^ 16'h0001;
        run_change(nv);
        wait_valid("s4_first");
        check("s4_stall_data", 64'(msg_data), 64'(chunk_of(nv, 0)));
        nv[15:0] = nv[15:0] ^ 16'h8000;
        run_change(nv);
        tick(4);
        check("s4_stale_kept", 64'(msg_data), 64'(nv[15:0] ^ 16'h8000));
        n0        = hs_cyc_q.size();
        msg_ready = 1'b1;
        wait_quiet("s4");
        check("s4_count", 64'(hs_cyc_q.size() - n0), 2);

        // Scenario 5: link drops with a stalled message.
        msg_ready = 1'b0;
        nv = m_in;
        nv[63:48] = 16'h5A5A;
        exp_q.push_back(exp_t'{3, 16'h5A5A});
        m_in = nv;
        vin  = nv;
        wait_valid("s5_valid");
        ip_ready = 1'b0;
        tick(3);
        check("s5_drain_valid", 64'(msg_valid), 1);
        check("s5_drain_idx", 64'(msg_idx), 3);
        n0        = hs_cyc_q.size();
        msg_ready = 1'b1;
        tick(10);
        check("s5_count", 64'(hs_cyc_q.size() - n0), 1);
        check("s5_idle_valid", 64'(msg_valid), 0);
        check("s5_pending", 64'(vw_pending), 0);
        check("s5_shadow", 64'(dut.r_shadow), strap);
        m_shadow = strap;

        // Scenario 6: reset in the middle of INIT.
        msg_ready = 1'b0;
        ip_ready  = 1'b1;
        wait_valid("s6_valid");
        check("s6_init_idx", 64'(msg_idx), 0);
        #2;
        rst = 1'b1;
        #1;
        check("s6_async_clear", 64'(msg_valid), 0);
        exp_q.delete();
        tick(2);
        push_init();
        m_rr      = 0;
        rst       = 1'b0;
        msg_ready = 1'b1;
        wait_quiet("s6");

        // Randomized changes against the rotation model, with random sink stalls.
        rand_ready = 1'b1;
        repeat (25) begin
            nv = m_in;
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 1) == 1) nv[c*CW +: CW] = nv[c*CW +: CW] ^ 16'($urandom);
            end
            run_change(nv);
            wait_quiet("rand");
        end
        rand_ready = 1'b0;
        tick(3);
        check("final_pending", 64'(vw_pending), 0);
        check("final_queue", 64'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
